// File: rtl/apb_master.sv
// APB master: turns single cmd_* requests into APB3 SETUP/ACCESS transfers.
// It reports each completion with a one-cycle rsp_valid pulse.
//
// Parameters
//   ADDR_WIDTH      PADDR / cmd_addr width
//   DATA_WIDTH      PWDATA / PRDATA / cmd_wdata / rsp_rdata width
//   TIMEOUT_CYCLES  ACCESS wait-state limit (only with APB_MASTER_TIMEOUT_EN)
//
// Ports
//   PCLK, PRESETn                clock, asynchronous active-high reset
//   cmd_valid/cmd_ready          command handshake (ready only while idle)
//   cmd_write/cmd_addr/cmd_wdata command payload, captured on acceptance
//   rsp_valid/rsp_rdata/rsp_err  completion pulse, read data, error flag
//   PSEL/PENABLE/PWRITE/PADDR/PWDATA/PRDATA/PREADY  APB bus
//
// Build option
//   `define APB_MASTER_TIMEOUT_EN  adds the wait-state counter. When PREADY
//   stays low for TIMEOUT_CYCLES ACCESS cycles, the transfer ends with rsp_err=1.
//   Without this macro ACCESS waits forever and rsp_err is tied to 0.

module apb_master #(
    parameter int unsigned ADDR_WIDTH     = 10,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic [DATA_WIDTH-1:0] PWDATA,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PREADY
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_e;

    state_e                  state_q, state_d;
    logic                    cmd_ready_q, cmd_ready_d;
    logic                    psel_q, psel_d;
    logic                    penable_q, penable_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic                    pwrite_q, pwrite_d;
    logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
    logic [DATA_WIDTH-1:0]   pwdata_q, pwdata_d;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                    accept_c;
    logic                    timeout_c;

    assign accept_c = (state_q == IDLE) && cmd_valid && cmd_ready_q;

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wait_q, wait_d;
    logic             rsp_err_q, rsp_err_d;

    // This sample is the TIMEOUT_CYCLES-th ACCESS cycle with PREADY low.
    assign timeout_c = (state_q == ACCESS) && !PREADY &&
                       (wait_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign rsp_err   = rsp_err_q;
`else
    // TIMEOUT_CYCLES only matters when the timeout logic is built in.
    assign timeout_c = 1'b0 & (TIMEOUT_CYCLES != 0);
    assign rsp_err   = 1'b0;
`endif

    // State and output registers
    always_ff @(posedge PCLK or posedge PRESETn) begin
        if (PRESETn) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_rdata_q <= '0;
`ifdef APB_MASTER_TIMEOUT_EN
            wait_q      <= '0;
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            rsp_valid_q <= rsp_valid_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_rdata_q <= rsp_rdata_d;
`ifdef APB_MASTER_TIMEOUT_EN
            wait_q      <= wait_d;
            rsp_err_q   <= rsp_err_d;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept_c) state_d = SETUP;
            SETUP:   state_d = ACCESS;
            ACCESS:  if (PREADY || timeout_c) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic: decode the upcoming state so every output is a flop
    always_comb begin
        cmd_ready_d = (state_d == IDLE);
        psel_d      = (state_d == SETUP) || (state_d == ACCESS);
        penable_d   = (state_d == ACCESS);
        rsp_valid_d = (state_d == RESP);
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_rdata_d = rsp_rdata_q;

        if (accept_c) begin
            pwrite_d = cmd_write;
            paddr_d  = cmd_addr;
            pwdata_d = cmd_wdata;
        end

        // Read data is taken only on the completing ACCESS edge.
        if ((state_q == ACCESS) && PREADY && !pwrite_q) begin
            rsp_rdata_d = PRDATA;
        end

`ifdef APB_MASTER_TIMEOUT_EN
        wait_d    = wait_q;
        rsp_err_d = (state_d == RESP) && timeout_c;
        if (accept_c) begin
            wait_d = '0;
        end else if ((state_q == ACCESS) && !PREADY) begin
            wait_d = wait_q + CNT_W'(1);
        end
`endif
    end

    assign cmd_ready = cmd_ready_q;
    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign rsp_valid = rsp_valid_q;
    assign PWRITE    = pwrite_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_apb_master.sv
// Testbench for apb_master. A transaction-level model predicts every output
// cycle by cycle from the stimulus alone. A negedge process compares the DUT
// against that model. Directed scenarios add literal latency and data checks.

module tb_apb_master;

    localparam int unsigned AW = 10;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 16;

    logic          PCLK      = 1'b0;
    logic          PRESETn   = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr  = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic [DW-1:0] PRDATA    = '0;
    logic          PREADY    = 1'b0;
    logic          cmd_ready, rsp_valid, rsp_err, PSEL, PENABLE, PWRITE;
    logic [AW-1:0] PADDR;
    logic [DW-1:0] PWDATA, rsp_rdata;

    always #5 PCLK = ~PCLK;

    apb_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- transaction-level model ----------------
    // A transfer is described by its first bus cycle (m_start) and its
    // response cycle (m_resp, -1 while still open); every output follows
    // from where the current cycle number falls relative to those two.
    int            m_start = -1;
    int            m_resp  = -1;
    int            m_waits = 0;
    bit            m_live  = 1'b0;
    bit            m_err   = 1'b0;
    logic          m_wr    = 1'b0;
    logic [AW-1:0] m_addr  = '0;
    logic [DW-1:0] m_wdata = '0;
    logic [DW-1:0] m_rdata = '0;

    function automatic bit busy(input int n);
        return (m_start >= 0) && (n >= m_start) && ((m_resp < 0) || (n <= m_resp));
    endfunction
    function automatic bit e_ready(input int n);
        return m_live && !busy(n);
    endfunction
    function automatic bit e_psel(input int n);
        return busy(n) && (n != m_resp);
    endfunction
    function automatic bit e_pen(input int n);
        return e_psel(n) && (n > m_start);
    endfunction

    always @(posedge PCLK) begin : model
        int n;
        n = cyc + 1;
        if (PRESETn) begin
            m_start = -1; m_resp = -1; m_waits = 0; m_live = 1'b0; m_err = 1'b0;
            m_wr = 1'b0; m_addr = '0; m_wdata = '0; m_rdata = '0;
        end else begin
            if (e_ready(cyc) && cmd_valid) begin
                m_start = n; m_resp = -1; m_waits = 0; m_err = 1'b0;
                m_wr = cmd_write; m_addr = cmd_addr; m_wdata = cmd_wdata;
            end else if (e_pen(cyc)) begin
                if (PREADY) begin
                    m_resp = n;
                    if (!m_wr) m_rdata = PRDATA;
                end else begin
                    m_waits++;
`ifdef APB_MASTER_TIMEOUT_EN
                    if (m_waits == int'(TO)) begin
                        m_resp = n;
                        m_err  = 1'b1;
                    end
`endif
                end
            end
            m_live = 1'b1;
        end
        cyc = n;
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge PCLK) begin : compare
        bit            x_rdy, x_sel, x_en, x_rv, x_err, x_wr;
        logic [AW-1:0] x_addr;
        logic [DW-1:0] x_wd, x_rd;
        if (PRESETn) begin
            x_rdy = 0; x_sel = 0; x_en = 0; x_rv = 0; x_err = 0; x_wr = 0;
            x_addr = '0; x_wd = '0; x_rd = '0;
        end else begin
            x_rdy  = e_ready(cyc);
            x_sel  = e_psel(cyc);
            x_en   = e_pen(cyc);
            x_rv   = (cyc == m_resp);
            x_err  = x_rv && m_err;
            x_wr   = m_wr;
            x_addr = m_addr;
            x_wd   = m_wdata;
            x_rd   = m_rdata;
        end
        chk("cmd_ready", 64'(cmd_ready), 64'(x_rdy));
        chk("PSEL",      64'(PSEL),      64'(x_sel));
        chk("PENABLE",   64'(PENABLE),   64'(x_en));
        chk("rsp_valid", 64'(rsp_valid), 64'(x_rv));
        chk("rsp_err",   64'(rsp_err),   64'(x_err));
        chk("PWRITE",    64'(PWRITE),    64'(x_wr));
        chk("PADDR",     64'(PADDR),     64'(x_addr));
        chk("PWDATA",    64'(PWDATA),    64'(x_wd));
        chk("rsp_rdata", 64'(rsp_rdata), 64'(x_rd));
    end

    // ---------------- APB completer ----------------
    // Outside ACCESS it drives PREADY=1 and inverted data; the master must ignore both.
    int            acc_cnt  = 0;
    int            wait_cfg = 0;
    bit            stuck    = 1'b0;
    logic [DW-1:0] rd_cfg   = '0;

    always @(negedge PCLK) begin : completer
        if (PSEL && PENABLE) begin
            PREADY = !stuck && (acc_cnt >= wait_cfg);
            PRDATA = rd_cfg;
            acc_cnt++;
        end else begin
            acc_cnt = 0;
            PREADY  = 1'b1;
            PRDATA  = ~rd_cfg;
        end
    end

    // ---------------- directed driver ----------------
    // Issue one command. Keep cmd_valid high with scrambled payload while busy.
    // Report latency (response cycle minus acceptance cycle) and the ACCESS cycle count.
    task automatic xfer(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input int waits, input logic [DW-1:0] rd, input bit expect_rsp,
                        output int lat, output int n_acc, output logic [AW-1:0] a_seen,
                        output logic [DW-1:0] wd_seen, output bit err_seen,
                        output logic [DW-1:0] rd_seen);
        int t;
        int acc;
        wait_cfg = waits; rd_cfg = rd;
        lat = -1; n_acc = 0; a_seen = '0; wd_seen = '0; err_seen = 1'b0; rd_seen = '0;
        @(negedge PCLK);
        cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_valid = 1'b1;
        t = 0;
        while (!cmd_ready && t < 20) begin
            @(negedge PCLK);
            t++;
        end
        chk("accept_in_time", 64'(t < 20), 64'(1));
        acc = cyc;
        @(negedge PCLK);
        cmd_write = !wr; cmd_addr = ~a; cmd_wdata = ~d;
        for (int k = 0; k < 100; k++) begin
            if (PSEL && PENABLE) begin
                if (n_acc == 0) begin
                    a_seen  = PADDR;
                    wd_seen = PWDATA;
                end
                n_acc++;
            end
            if (rsp_valid) begin
                lat = cyc - acc; err_seen = rsp_err; rd_seen = rsp_rdata;
                break;
            end
            @(negedge PCLK);
        end
        cmd_valid = 1'b0;
        if (expect_rsp) chk("rsp_in_time", 64'(lat >= 0), 64'(1));
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int            lat, nacc, t, k, cnt;
        int            accs [3];
        logic [AW-1:0] a_s;
        logic [DW-1:0] wd_s, rd_s;
        bit            err_s;

        #2 PRESETn = 1'b1;
        repeat (2) @(negedge PCLK);
        chk("reset_cmd_ready", 64'(cmd_ready), 64'(0));
        chk("reset_psel",      64'(PSEL),      64'(0));
        chk("reset_paddr",     64'(PADDR),     64'(0));
        PRESETn = 1'b0;
        @(posedge PCLK);
        #1 chk("ready_after_release", 64'(cmd_ready), 64'(1));

        // Zero-wait write
        xfer(1'b1, AW'(10), 32'hA5A5_5A5A, 0, 32'h0, 1'b1, lat, nacc, a_s, wd_s, err_s, rd_s);
        chk("wr_latency",  64'(lat),  64'(3));
        chk("wr_access_n", 64'(nacc), 64'(1));
        chk("wr_paddr",    64'(a_s),  64'(10));
        chk("wr_pwdata",   64'(wd_s), 64'(32'hA5A5_5A5A));
        chk("wr_err",      64'(err_s), 64'(0));

        // Write at the top address with one wait state
        xfer(1'b1, AW'(10'h3FF), 32'hFFFF_FFFF, 1, 32'h0, 1'b1, lat, nacc, a_s, wd_s, err_s, rd_s);
        chk("wr1_latency",  64'(lat),  64'(4));
        chk("wr1_access_n", 64'(nacc), 64'(2));
        chk("wr1_paddr",    64'(a_s),  64'(10'h3FF));

        // Read with three wait states
        xfer(1'b0, AW'(20), 32'h0, 3, 32'hDEAD_BEEF, 1'b1, lat, nacc, a_s, wd_s, err_s, rd_s);
        chk("rd3_latency",  64'(lat),   64'(6));
        chk("rd3_access_n", 64'(nacc),  64'(4));
        chk("rd3_rdata",    64'(rd_s),  64'(32'hDEAD_BEEF));
        chk("rd3_err",      64'(err_s), 64'(0));

        // Zero-wait read at address 0
        xfer(1'b0, AW'(0), 32'h0, 0, 32'h0BAD_F00D, 1'b1, lat, nacc, a_s, wd_s, err_s, rd_s);
        chk("rd0_latency", 64'(lat),  64'(3));
        chk("rd0_rdata",   64'(rd_s), 64'(32'h0BAD_F00D));

        // Back-to-back commands with cmd_valid held high and payload changing every cycle
        wait_cfg = 0; rd_cfg = 32'h5555_AAAA;
        @(negedge PCLK);
        cmd_valid = 1'b1;
        k = 0; t = 0;
        while (k < 3 && t < 40) begin
            cmd_addr  = AW'(100 + t);
            cmd_wdata = 32'hC0DE_0000 + DW'(t);
            cmd_write = t[2];
            if (cmd_ready) begin
                accs[k] = cyc;
                k++;
            end
            @(negedge PCLK);
            t++;
        end
        cmd_valid = 1'b0;
        chk("b2b_count", 64'(k), 64'(3));
        chk("b2b_gap01", 64'(accs[1] - accs[0]), 64'(4));
        chk("b2b_gap12", 64'(accs[2] - accs[1]), 64'(4));
        repeat (5) @(negedge PCLK);

        // PREADY stuck low
        xfer(1'b0, AW'(20), 32'h0, 0, 32'hDEAD_BEEF, 1'b1, lat, nacc, a_s, wd_s, err_s, rd_s);
        chk("pre_stuck_rdata", 64'(rd_s), 64'(32'hDEAD_BEEF));
        stuck = 1'b1;
`ifdef APB_MASTER_TIMEOUT_EN
        xfer(1'b0, AW'(40), 32'h0, 0, 32'h1111_2222, 1'b1, lat, nacc, a_s, wd_s, err_s, rd_s);
        stuck = 1'b0;
        chk("to_latency",  64'(lat),   64'(18));
        chk("to_access_n", 64'(nacc),  64'(16));
        chk("to_err",      64'(err_s), 64'(1));
        chk("to_rdata",    64'(rd_s),  64'(32'hDEAD_BEEF));
`else
        xfer(1'b0, AW'(40), 32'h0, 0, 32'h1111_2222, 1'b0, lat, nacc, a_s, wd_s, err_s, rd_s);
        chk("stuck_no_rsp", 64'(lat), 64'(-1));
        chk("stuck_in_access", 64'(PSEL && PENABLE), 64'(1));
        @(negedge PCLK);
        #1 PRESETn = 1'b1;
        stuck = 1'b0;
        repeat (2) @(negedge PCLK);
        PRESETn = 1'b0;
`endif
        repeat (2) @(negedge PCLK);

        // Reset asserted during ACCESS of a read
        wait_cfg = 10; rd_cfg = 32'h1234_5678;
        @(negedge PCLK);
        cmd_write = 1'b0; cmd_addr = AW'(30); cmd_valid = 1'b1;
        t = 0;
        while (!cmd_ready && t < 20) begin
            @(negedge PCLK);
            t++;
        end
        @(negedge PCLK);
        cmd_valid = 1'b0;
        t = 0;
        while (!(PSEL && PENABLE) && t < 10) begin
            @(negedge PCLK);
            t++;
        end
        chk("rst_reached_access", 64'(PSEL && PENABLE), 64'(1));
        @(negedge PCLK);
        #1 PRESETn = 1'b1;
        #1;
        chk("rst_psel_now",    64'(PSEL),      64'(0));
        chk("rst_penable_now", 64'(PENABLE),   64'(0));
        chk("rst_ready_now",   64'(cmd_ready), 64'(0));
        chk("rst_rdata_now",   64'(rsp_rdata), 64'(0));
        repeat (2) @(negedge PCLK);
        PRESETn = 1'b0;
        @(posedge PCLK);
        #1 chk("rst_ready_first_edge", 64'(cmd_ready), 64'(1));
        cnt = 0;
        repeat (10) begin
            @(negedge PCLK);
            if (rsp_valid) cnt++;
        end
        chk("rst_no_rsp", 64'(cnt), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
